vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_sync_edge.sv | 22 ++
 rtl/vga_capture.sv | 165 ++++++++++++++++
 tb/tb_vga_capture.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA frame capture block.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_VS     = 2'd1,
        WAIT_ACTIVE = 2'd2,
        CAPTURE     = 2'd3
    } state_t;

    typedef logic [23:0] pixel_t;

    localparam int FB_W_DEF   = 280;
    localparam int FB_H_DEF   = 192;
    localparam int ADDR_W_DEF = 16;

endpackage

// File: rtl/vga_sync_edge.sv
// Falling-edge detector on a pix_ce-qualified input. The held sample presets
// high so the line is treated as inactive (high) coming out of reset.
module vga_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ce,
    input  logic i_sig,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_prev <= 1'b1;
        else if (i_ce)
            r_prev <= i_sig;
    end

    assign o_fall = i_ce & r_prev & ~i_sig;

endmodule

// File: rtl/vga_capture.sv
// Captures one (arm) or every (cont) VGA frame into a framebuffer write port.
// Define VGA_CAPTURE_DOWNSAMPLE_EN to keep only even columns/lines (2x2 decimation).
module vga_capture
    import vga_pkg::*;
#(
    parameter int FB_W   = FB_W_DEF,
    parameter int FB_H   = FB_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              pix_ce,
    input  logic              VGA_HS,
    input  logic              VGA_VS,
    input  logic              VGA_BLANK_N,
    input  logic [7:0]        VGA_R,
    input  logic [7:0]        VGA_G,
    input  logic [7:0]        VGA_B,
    input  logic              arm,
    input  logic              cont,
    output logic [ADDR_W-1:0] fb_adr_w,
    output pixel_t            fb_d,
    output logic              fb_we,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] L_W = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] L_H = ADDR_W'(FB_H);

    state_t            r_state, w_next;
    logic              w_vs_fall, w_bl_fall;
    logic              w_keep_px, w_keep_ln;
    logic              w_clr, w_pix, w_eol, w_store, w_done, w_err;
    logic [ADDR_W-1:0] r_kcol, r_klines, r_base, r_adr;
    pixel_t            r_d;
    logic              r_we, r_done, r_err;
    logic              w_unused;

    assign w_unused = VGA_HS;

    vga_sync_edge u_vs_edge (
        .i_clk (CLOCK_50),
        .i_rst (reset),
        .i_ce  (pix_ce),
        .i_sig (VGA_VS),
        .o_fall(w_vs_fall)
    );

    vga_sync_edge u_bl_edge (
        .i_clk (CLOCK_50),
        .i_rst (reset),
        .i_ce  (pix_ce),
        .i_sig (VGA_BLANK_N),
        .o_fall(w_bl_fall)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            IDLE:        if (arm || cont) w_next = WAIT_VS;
            WAIT_VS:     if (w_vs_fall) w_next = WAIT_ACTIVE;
            WAIT_ACTIVE: if (pix_ce && VGA_BLANK_N) w_next = CAPTURE;
            CAPTURE: begin
                // The frame-closing VS edge also opens the next frame in continuous mode.
                if (w_vs_fall) begin
                    w_done = (r_klines >= L_H);
                    w_err  = (r_klines <  L_H);
                    w_next = cont ? WAIT_ACTIVE : IDLE;
                end
            end
            default:     w_next = IDLE;
        endcase
    end

    // Counters are held clear outside an open frame; the first active pixel is (0,0).
    assign w_clr   = !(r_state == WAIT_ACTIVE || r_state == CAPTURE) ||
                     (r_state == CAPTURE && w_vs_fall);
    assign w_pix   = !w_clr && pix_ce && VGA_BLANK_N;
    assign w_eol   = !w_clr && (r_state == CAPTURE) && w_bl_fall;
    assign w_store = w_pix && w_keep_px && w_keep_ln && (r_kcol < L_W) && (r_klines < L_H);

`ifdef VGA_CAPTURE_DOWNSAMPLE_EN
    logic r_cpar, r_lpar;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_cpar <= 1'b0;
            r_lpar <= 1'b0;
        end else if (w_clr) begin
            r_cpar <= 1'b0;
            r_lpar <= 1'b0;
        end else if (w_pix) begin
            r_cpar <= ~r_cpar;
        end else if (w_eol) begin
            r_cpar <= 1'b0;
            r_lpar <= ~r_lpar;
        end
    end

    assign w_keep_px = ~r_cpar;
    assign w_keep_ln = ~r_lpar;
`else
    assign w_keep_px = 1'b1;
    assign w_keep_ln = 1'b1;
`endif

    // Kept counters saturate at the framebuffer size, so the address never wraps.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_kcol   <= '0;
            r_klines <= '0;
            r_base   <= '0;
        end else if (w_clr) begin
            r_kcol   <= '0;
            r_klines <= '0;
            r_base   <= '0;
        end else if (w_pix) begin
            if (w_keep_px && r_kcol < L_W)
                r_kcol <= r_kcol + 1'b1;
        end else if (w_eol) begin
            r_kcol <= '0;
            if (w_keep_ln && r_klines < L_H) begin
                r_klines <= r_klines + 1'b1;
                r_base   <= r_base + L_W;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_adr  <= '0;
            r_d    <= '0;
        end else begin
            r_we   <= w_store;
            r_done <= w_done;
            r_err  <= w_err;
            if (w_store) begin
                r_adr <= r_base + r_kcol;
                r_d   <= {VGA_R, VGA_G, VGA_B};
            end
        end
    end

    assign fb_we      = r_we;
    assign fb_adr_w   = r_adr;
    assign fb_d       = r_d;
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture with a reduced 20x12 framebuffer; expected writes come
// from a pixel-coordinate model pushed into a scoreboard queue.
module tb_vga_capture;

    localparam int TW = 20;
    localparam int TH = 12;
    localparam int AW = 16;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          pix_ce = 1'b0;
    logic          VGA_HS = 1'b1;
    logic          VGA_VS = 1'b1;
    logic          VGA_BLANK_N = 1'b0;
    logic [7:0]    VGA_R = '0, VGA_G = '0, VGA_B = '0;
    logic          arm = 1'b0;
    logic          cont = 1'b0;
    logic [AW-1:0] fb_adr_w;
    logic [23:0]   fb_d;
    logic          fb_we, busy, frame_done, frame_err;

    typedef struct {
        logic [AW-1:0] adr;
        logic [23:0]   d;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk = 0, n_err = 0;
    int  n_wr = 0, n_done = 0, n_ferr = 0, n_adr0 = 0, n_wr0 = 0;
    logic [AW-1:0] last_adr = '0;

    vga_capture #(.FB_W(TW), .FB_H(TH), .ADDR_W(AW)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .arm        (arm),
        .cont       (cont),
        .fb_adr_w   (fb_adr_w),
        .fb_d       (fb_d),
        .fb_we      (fb_we),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Write monitor: outputs are sampled 1 time unit after the rising edge.
    always @(posedge CLOCK_50) begin : mon
        wr_t e;
        #1;
        if (frame_done) n_done++;
        if (frame_err)  n_ferr++;
        if (fb_we) begin
            n_wr++;
            last_adr = fb_adr_w;
            if (fb_adr_w == '0) n_adr0++;
            chk("we_after_ce", pix_ce, 1'b1);
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", fb_we, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_adr", fb_adr_w, e.adr);
                chk("wr_data", fb_d, e.d);
            end
        end
    end

    initial begin
        #(80000 * 20);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One pixel slot: pix_ce high for exactly one cycle, then 'idle' extra low cycles.
    task automatic pix(input logic vs, input logic bl, input logic [23:0] rgb,
                       input int idle, input logic a);
        @(negedge CLOCK_50);
        pix_ce = 1'b1;
        VGA_VS = vs;
        VGA_BLANK_N = bl;
        {VGA_R, VGA_G, VGA_B} = rgb;
        arm = a;
        @(negedge CLOCK_50);
        pix_ce = 1'b0;
        arm = 1'b0;
        repeat (idle) @(negedge CLOCK_50);
    endtask

    task automatic pulse_arm();
        @(negedge CLOCK_50);
        arm = 1'b1;
        @(negedge CLOCK_50);
        arm = 1'b0;
    endtask

    task automatic drive_vsync(input logic arm_on_fall);
        repeat (2) pix(1'b1, 1'b0, '0, int'($urandom_range(0, 1)), 1'b0);
        pix(1'b0, 1'b0, '0, int'($urandom_range(0, 1)), arm_on_fall);
        repeat (3) pix(1'b0, 1'b0, '0, int'($urandom_range(0, 1)), 1'b0);
        repeat (4) pix(1'b1, 1'b0, '0, int'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic drive_active(input int w, input int h, input bit keep_exp,
                                input int gap_idx, input int arm_idx, input int abort_at);
        int idx, kx, ky, idle;
        bit keep;
        logic [23:0] rgb;
        wr_t e;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                idx = y * w + x;
                if (idx == abort_at) return;
                rgb = 24'($urandom);
`ifdef VGA_CAPTURE_DOWNSAMPLE_EN
                keep = (x % 2 == 0) && (y % 2 == 0);
                kx = x / 2;
                ky = y / 2;
`else
                keep = 1'b1;
                kx = x;
                ky = y;
`endif
                if (keep_exp && keep && kx < TW && ky < TH) begin
                    e.adr = AW'(ky * TW + kx);
                    e.d   = rgb;
                    exp_q.push_back(e);
                end
                idle = (idx == gap_idx) ? 4 :
                       (idx == abort_at - 1) ? 0 : int'($urandom_range(0, 1));
                pix(1'b1, 1'b1, rgb, idle, idx == arm_idx);
            end
            repeat (4) pix(1'b1, 1'b0, '0, int'($urandom_range(0, 1)), 1'b0);
        end
        repeat (3) pix(1'b1, 1'b0, '0, 1, 1'b0);
    endtask

    task automatic clr_stats();
        n_wr = 0;
        n_done = 0;
        n_ferr = 0;
        n_adr0 = 0;
    endtask

    initial begin
        int short_wr, abort_wr;
`ifdef VGA_CAPTURE_DOWNSAMPLE_EN
        short_wr = 3 * TW;
        abort_wr = TW + 6;
`else
        short_wr = 5 * TW;
        abort_wr = 2 * TW + 11;
`endif
        repeat (3) @(negedge CLOCK_50);
        chk("rst_we", fb_we, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_adr", fb_adr_w, '0);
        chk("rst_d", fb_d, '0);
        reset = 1'b0;

        // No arm, no cont: nothing is captured.
        drive_vsync(1'b0);
        drive_active(24, 14, 1'b0, -1, -1, -1);
        drive_vsync(1'b0);
        chk("idle_wr", n_wr, 0);
        chk("idle_busy", busy, 1'b0);

        // Armed full frame with a 5-cycle pix_ce gap and a stray arm mid-capture.
        clr_stats();
        pulse_arm();
        chk("arm_busy", busy, 1'b1);
        drive_vsync(1'b0);
        drive_active(2 * TW, 2 * TH, 1'b1, 3 * 2 * TW + TW / 2, 5 * 2 * TW, -1);
        drive_vsync(1'b0);
        chk("full_wr", n_wr, TW * TH);
        chk("full_last_adr", last_adr, TW * TH - 1);
        chk("full_done", n_done, 1);
        chk("full_err", n_ferr, 0);
        chk("full_q", exp_q.size(), 0);
        chk("full_busy", busy, 1'b0);

        // Frame ends after 5 active lines: aborted.
        clr_stats();
        pulse_arm();
        drive_vsync(1'b0);
        drive_active(2 * TW, 5, 1'b1, -1, -1, -1);
        drive_vsync(1'b0);
        chk("short_err", n_ferr, 1);
        chk("short_done", n_done, 0);
        chk("short_wr", n_wr, short_wr);
        chk("short_q", exp_q.size(), 0);
        chk("short_busy", busy, 1'b0);

        // Continuous mode for three frames.
        clr_stats();
        cont = 1'b1;
        drive_vsync(1'b0);
        for (int f = 0; f < 3; f++) begin
            drive_active(2 * TW, 2 * TH, 1'b1, -1, -1, -1);
            if (f == 2) cont = 1'b0;
            drive_vsync(1'b0);
        end
        chk("cont_done", n_done, 3);
        chk("cont_err", n_ferr, 0);
        chk("cont_adr0", n_adr0, 3);
        chk("cont_wr", n_wr, 3 * TW * TH);
        chk("cont_busy", busy, 1'b0);

        // Reset raised mid-capture, right after a stored pixel.
        clr_stats();
        pulse_arm();
        drive_vsync(1'b0);
        drive_active(2 * TW, 2 * TH, 1'b1, -1, -1, 2 * 2 * TW + 11);
        chk("abort_we_pre", fb_we, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort_we", fb_we, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_adr", fb_adr_w, '0);
        chk("abort_q", exp_q.size(), 0);
        chk("abort_wr", n_wr, abort_wr);
        n_wr0 = n_wr;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        drive_vsync(1'b0);
        drive_active(2 * TW, 2 * TH, 1'b0, -1, -1, -1);
        drive_vsync(1'b0);
        chk("post_rst_wr", n_wr, n_wr0);
        chk("post_rst_err", n_ferr, 0);
        chk("post_rst_busy", busy, 1'b0);

        // Arm on the same cycle as a VS fall: that frame is skipped, the next is captured.
        clr_stats();
        drive_vsync(1'b1);
        chk("samecyc_busy", busy, 1'b1);
        drive_active(2 * TW, 2 * TH, 1'b0, -1, -1, -1);
        chk("samecyc_wr0", n_wr, 0);
        drive_vsync(1'b0);
        drive_active(2 * TW, 2 * TH, 1'b1, -1, -1, -1);
        drive_vsync(1'b0);
        chk("samecyc_done", n_done, 1);
        chk("samecyc_wr", n_wr, TW * TH);
        chk("samecyc_busy_end", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
